// File: rtl/neurram_wupdate_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | neurram_wupdate_sequencer: programmable weight-update pulse-train sequencer  |
// | for NUM_CH cores. Define WUPDATE_ABORT_EN to add the i_abort input.          |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module neurram_wupdate_sequencer #(
    parameter int NUM_CH = 48,
    parameter int CNT_W  = 32,
    parameter int NP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_ch_mask,
    input  logic              i_read_trigger,
    input  logic              i_read_ack,
    input  logic              i_vread_on,
    input  logic              i_program_trigger,
    input  logic              i_wupdate_mode_trigger,
    input  logic [CNT_W-1:0]  i_setup_width,
    input  logic [CNT_W-1:0]  i_pulse_width,
    input  logic [CNT_W-1:0]  i_gap_width,
    input  logic [CNT_W-1:0]  i_hold_width,
    input  logic [CNT_W-1:0]  i_wupdate_mode_width,
    input  logic [NP_W-1:0]   i_pulse_count,
    input  logic              i_program_ack,
`ifdef WUPDATE_ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_program_done,
    output logic              o_busy,
    output logic [NP_W-1:0]   o_pulses_issued,
    output logic [NUM_CH-1:0] o_wupdate_mode,
    output logic [NUM_CH-1:0] o_wupdate_pulse
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_HOLD  = 3'd5,
        S_MODE  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [NP_W-1:0]  c_NP_ONE  = NP_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CH-1:0]   r_mask;
    logic [CNT_W-1:0]    r_setup_w;
    logic [CNT_W-1:0]    r_pulse_w;
    logic [CNT_W-1:0]    r_gap_w;
    logic [CNT_W-1:0]    r_hold_w;
    logic [CNT_W-1:0]    r_mode_w;
    logic [NP_W-1:0]     r_np;
    logic [NP_W-1:0]     r_issued;
    logic                r_done;
    logic                r_busy;
    logic [NUM_CH-1:0]   r_mode_o;
    logic [NUM_CH-1:0]   r_pulse_o;

    logic [CNT_W-1:0]    w_pulse_w_eff;
    logic [CNT_W-1:0]    w_gap_w_eff;
    logic [CNT_W-1:0]    w_mode_w_eff;
    logic [NP_W-1:0]     w_np_eff;
    logic                w_more_pulses;
    logic                w_abort;

    // Zero-valued fields are normalised once at latch time so phases never see 0.
    assign w_pulse_w_eff = (i_pulse_width == '0)        ? c_CNT_ONE : i_pulse_width;
    assign w_gap_w_eff   = (i_gap_width == '0)          ? c_CNT_ONE : i_gap_width;
    assign w_mode_w_eff  = (i_wupdate_mode_width == '0) ? c_CNT_ONE : i_wupdate_mode_width;
    assign w_np_eff      = (i_pulse_count == '0)        ? c_NP_ONE  : i_pulse_count;

    // Extra bit keeps issued+1 from wrapping when pulse_count is at its maximum.
    assign w_more_pulses = ({1'b0, r_issued} + (NP_W+1)'(1)) < {1'b0, r_np};

`ifdef WUPDATE_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_setup_w <= '0;
            r_pulse_w <= '0;
            r_gap_w   <= '0;
            r_hold_w  <= '0;
            r_mode_w  <= '0;
            r_np      <= '0;
            r_issued  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_mode_o  <= '0;
            r_pulse_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (i_read_trigger) begin
                        r_state   <= S_READ;
                        r_busy    <= 1'b1;
                        r_mask    <= i_ch_mask;
                        r_mode_o  <= i_ch_mask & {NUM_CH{i_vread_on}};
                        r_pulse_o <= i_ch_mask & {NUM_CH{i_vread_on}};
                    end else if (i_program_trigger || i_wupdate_mode_trigger) begin
                        r_busy    <= 1'b1;
                        r_mask    <= i_ch_mask;
                        r_setup_w <= i_setup_width;
                        r_pulse_w <= w_pulse_w_eff;
                        r_gap_w   <= w_gap_w_eff;
                        r_hold_w  <= i_hold_width;
                        r_mode_w  <= w_mode_w_eff;
                        r_np      <= w_np_eff;
                        r_mode_o  <= i_ch_mask;
                        if (!i_program_trigger) begin
                            r_state   <= S_MODE;
                            r_pulse_o <= '0;
                        end else begin
                            r_issued <= '0;
                            if (i_setup_width != '0) begin
                                r_state   <= S_SETUP;
                                r_pulse_o <= '0;
                            end else begin
                                r_state   <= S_PULSE;
                                r_pulse_o <= i_ch_mask;
                            end
                        end
                    end
                end

                S_READ: begin
                    if (i_read_ack) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_mode_o  <= '0;
                        r_pulse_o <= '0;
                    end else begin
                        r_mode_o  <= r_mask & {NUM_CH{i_vread_on}};
                        r_pulse_o <= r_mask & {NUM_CH{i_vread_on}};
                    end
                end

                S_SETUP, S_GAP, S_HOLD, S_MODE: begin
                    if (w_abort ||
                        (r_state == S_HOLD && r_cnt == r_hold_w - c_CNT_ONE) ||
                        (r_state == S_MODE && r_cnt == r_mode_w - c_CNT_ONE)) begin
                        r_state   <= S_DONE;
                        r_cnt     <= '0;
                        r_done    <= 1'b1;
                        r_mode_o  <= '0;
                        r_pulse_o <= '0;
                    end else if ((r_state == S_SETUP && r_cnt == r_setup_w - c_CNT_ONE) ||
                                 (r_state == S_GAP   && r_cnt == r_gap_w - c_CNT_ONE)) begin
                        r_state   <= S_PULSE;
                        r_cnt     <= '0;
                        r_pulse_o <= r_mask;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_PULSE: begin
                    if (w_abort) begin
                        r_state   <= S_DONE;
                        r_cnt     <= '0;
                        r_done    <= 1'b1;
                        r_mode_o  <= '0;
                        r_pulse_o <= '0;
                    end else if (r_cnt == r_pulse_w - c_CNT_ONE) begin
                        r_cnt     <= '0;
                        r_issued  <= r_issued + c_NP_ONE;
                        r_pulse_o <= '0;
                        if (w_more_pulses) begin
                            r_state <= S_GAP;
                        end else if (r_hold_w != '0) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_mode_o <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_DONE: begin
                    if (i_program_ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_mode_o  <= '0;
                    r_pulse_o <= '0;
                end
            endcase
        end
    end

    assign o_program_done  = r_done;
    assign o_busy          = r_busy;
    assign o_pulses_issued = r_issued;
    assign o_wupdate_mode  = r_mode_o;
    assign o_wupdate_pulse = r_pulse_o;

endmodule
`default_nettype wire

// File: doc/neurram_wupdate_sequencer.md
Name: neurram_wupdate_sequencer

Overview:
- Parametrised successor to the single-pulse weight-update controller.
- Drives per-channel wupdate_mode / wupdate_pulse for NUM_CH cores from one EP-controlled sequencer.
- Adds a programmable pulse train (setup, N pulses, gaps, hold), a latched channel mask, busy/status outputs, and a mode-only window.
- Sits between the EP wire/trigger interface and the NeuRRAM core array.

Parameters:
- NUM_CH, 48, number of core channels driven.
- CNT_W, 32, width of every timing field and of the cycle counter.
- NP_W, 16, width of pulse_count and pulses_issued.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- ch_mask  in  NUM_CH  channel enable; latched when a trigger is accepted.
- read_trigger  in  1  enter read mode.
- read_ack  in  1  leave read mode.
- vread_on  in  1  read-voltage enable while in read mode.
- program_trigger  in  1  start the pulse train.
- wupdate_mode_trigger  in  1  start a mode-only window.
- setup_width  in  CNT_W  mode-high, pulse-low cycles before the first pulse.
- pulse_width  in  CNT_W  high cycles per pulse.
- gap_width  in  CNT_W  low cycles between pulses.
- hold_width  in  CNT_W  mode-high cycles after the last pulse.
- wupdate_mode_width  in  CNT_W  mode-only window length.
- pulse_count  in  NP_W  pulses per train.
- program_ack  in  1  clears program_done.
- program_done  out  1  sequence complete.
- busy  out  1  high whenever state is not IDLE.
- pulses_issued  out  NP_W  pulses completed in the current or last train.
- wupdate_mode  out  NUM_CH  per-channel mode.
- wupdate_pulse  out  NUM_CH  per-channel pulse.

Behaviour:
- Reset: sampled at posedge clk with rst==0. State=IDLE; all outputs, mask register and counters are 0. Reset mid-sequence drops outputs on that edge and has priority over everything.
- All outputs are registered. Any field value of 0 in pulse_width, gap_width or pulse_count is treated as 1. setup_width==0 and hold_width==0 skip that phase.
- Widths, pulse_count and ch_mask are latched on trigger acceptance. Later input changes are ignored until IDLE.
- States: IDLE, READ, SETUP, PULSE, GAP, HOLD, MODE, DONE.
- IDLE: accepts triggers with priority read > program > mode, sampled at edge k.
  - Read accepted: next state READ.
  - Program accepted: next state SETUP if setup_width>0, else PULSE.
  - Mode accepted: next state MODE.
  - pulses_issued clears to 0 on program acceptance.
- Output timing: outputs for a state appear from the edge that enters it (edge k+1 for the first state after trigger).
- READ: wupdate_mode = wupdate_pulse = mask & {NUM_CH{vread_on}}. vread_on is tracked with 1-cycle registered latency. read_ack sampled high -> IDLE, outputs 0 on the next edge.
- SETUP: mode=mask, pulse=0, for exactly setup_width cycles, then PULSE.
- PULSE: mode=mask, pulse=mask, for exactly pulse_width cycles. pulses_issued increments on exit.
  - If pulses_issued+1 < pulse_count -> GAP.
  - Else -> HOLD if hold_width>0, else DONE.
- GAP: mode=mask, pulse=0, for gap_width cycles, then PULSE.
- HOLD: mode=mask, pulse=0, for hold_width cycles, then DONE.
- MODE: mode=mask, pulse=0, for wupdate_mode_width cycles (0 treated as 1), then DONE.
- DONE: mode=pulse=0, program_done=1. program_ack sampled high -> IDLE, and program_done falls on the same edge.
- program_ack outside DONE is ignored. Triggers outside IDLE are ignored. They are not queued.
- Cycle counter: CNT_W bits, cleared on each phase entry. It never wraps inside a phase because the compare happens at width-1.

Optional Feature:
- Macro: WUPDATE_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort sampled high in SETUP, PULSE, GAP, HOLD or MODE forces mode=pulse=0 on the next edge and enters DONE.
  - pulses_issued keeps only fully completed pulses.
  - abort is ignored in IDLE, READ and DONE.
- Undefined: no abort port; sequences always run to completion.

Test Plan:
- Reset: rst=0 mid-PULSE -> next edge all outputs 0, busy=0, state IDLE.
- Train: mask=0x5, setup=3, pulse=4, gap=2, hold=5, count=3 -> ch0/ch2 pulse high 4 cycles ×3 with 2-cycle gaps; mode high 3+4+2+4+2+4+5=24 cycles; ch1 stays 0; pulses_issued=3; program_done until ack.
- Zero fields: pulse_width=0, count=0, setup=0, hold=0 -> one 1-cycle pulse, then DONE.
- Simultaneous read_trigger+program_trigger in IDLE -> READ. With vread_on=1, mode=pulse=mask one cycle later; read_ack -> outputs 0, no program_done.
- Mode-only: wupdate_mode_width=10 -> mode=mask exactly 10 cycles, pulse never high, then program_done=1.
- With WUPDATE_ABORT_EN: abort in 2nd PULSE of count=5 -> outputs 0 next edge, DONE, pulses_issued=1.
